fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the immediate/decode unit. It owns the program counter and issues word-aligned requests to instruction memory over a valid/ready channel. Returned words are buffered in a small in-order FIFO and handed to decode as `{inst, pc}` pairs over a valid/ready channel. A redirect from execute (branch/jump) flushes everything in flight.

---
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage channel bundle: instruction-memory request/response,
// redirect from execute, and the {inst, pc} hand-off to decode.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_inst, dec_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_inst, dec_pc,
    output dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches,
// tags in-order responses with their address and buffers them for decode.
// A redirect flushes buffered entries and discards responses still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   infl_pc   [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] infl_rd, infl_wr;

  logic          redirect;
  logic          credit_ok;
  logic          req_valid;
  logic          req_fire;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          dec_fire;
  logic [CW-1:0] drop_redir;

  assign redirect   = bus.redirect_valid;
  assign credit_ok  = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_W;
  assign req_fire   = req_valid && bus.imem_req_ready;
  assign rsp_keep   = bus.imem_rsp_valid && (drop == '0) && !redirect;
  assign rsp_drop   = bus.imem_rsp_valid && (drop != '0);
  assign dec_fire   = (count != '0) && bus.dec_ready && !redirect;
  // A response landing in the redirect cycle is itself stale, so it is
  // subtracted here rather than counted into the drop budget.
  assign drop_redir = outstanding - CW'(bus.imem_rsp_valid);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.dec_valid      = (count != '0);
  assign bus.dec_inst       = fifo_inst[rd_ptr];
  assign bus.dec_pc         = fifo_pc[rd_ptr];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // Next-state selection and credit-gated request valid
  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    case (state)
      BOOT:  state_nxt = RUN;
      RUN:   req_valid = credit_ok && !redirect;
      DRAIN: if (rsp_drop && (drop == CW'(1))) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
    if (redirect) state_nxt = (drop_redir != '0) ? DRAIN : RUN;
  end

  // PC, in-flight/drop counters and buffer occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (redirect) begin
        pc    <= {bus.redirect_pc[31:2], 2'b00};
        drop  <= drop_redir;
        count <= '0;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (rsp_drop) drop <= drop - CW'(1);
        count <= count + CW'(rsp_keep) - CW'(dec_fire);
      end
    end
  end

  // In-flight address queue: tags each kept response with its fetch PC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      infl_rd <= '0;
      infl_wr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) infl_pc[i] <= '0;
    end else if (redirect) begin
      infl_rd <= '0;
      infl_wr <= '0;
    end else begin
      if (req_fire) begin
        infl_pc[infl_wr] <= pc;
        infl_wr          <= infl_wr + AW'(1);
      end
      if (rsp_keep) infl_rd <= infl_rd + AW'(1);
    end
  end

  // Decode FIFO storage; reset contents give the NOP/0 idle outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_inst[i] <= NOP;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (rsp_keep) begin
        fifo_inst[wr_ptr] <= bus.imem_rsp_data;
        fifo_pc[wr_ptr]   <= infl_pc[infl_rd];
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (dec_fire) rd_ptr <= rd_ptr + AW'(1);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with configurable
// latency and stalls, plus a scoreboard of {pc, inst} expected at decode.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h100;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } dec_t;

  logic clk;
  logic rst_n;
  fetch_unit_if fbus ();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fbus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mem_t        memq[$];
  dec_t        expq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned up = 0;
  bit          just_reset = 0;
  int unsigned lat = 1;
  bit          rdy_cfg = 1;
  int unsigned stall_left = 0;
  bit          redir_req = 0;
  logic [31:0] redir_target = '0;
  logic [31:0] exp_pc = RESET_PC;
  int unsigned nreq = 0;
  int unsigned hs_cnt = 0;
  int          first_req_up = -1;
  int          first_dec_up = -1;
  logic [31:0] first_req_addr = '0;
  logic [31:0] last_acc = '0;
  bit          saw_wrap = 0;
  int unsigned stall_seen = 0;
  int unsigned dropped_cnt = 0;
  bit          want_post_redir = 0;
  logic [31:0] post_redir_pc = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a ^ 32'hA5C3_0F00) + 32'h11;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check and advance the model,
  // then step through the rising edge back to the next falling edge.
  task automatic do_cycle();
    bit          rv;
    bit          exp_req;
    int unsigned stale_n;
    mem_t        m;
    fbus.redirect_valid = redir_req && rst_n;
    fbus.redirect_pc    = redir_target;
    fbus.dec_ready      = rdy_cfg;
    fbus.imem_req_ready = (stall_left == 0);
    if (stall_left != 0) stall_left--;
    rv = rst_n && (memq.size() != 0) && (memq[0].due <= cyc);
    fbus.imem_rsp_valid = rv;
    fbus.imem_rsp_data  = rv ? mem_data(memq[0].addr) : 32'hDEAD_BEEF;
    #1;
    if (!rst_n) begin
      memq.delete();
      expq.delete();
      exp_pc     = RESET_PC;
      up         = 0;
      just_reset = 1;
    end else begin
      if (just_reset) begin
        check_eq("rst_req_valid", 32'(fbus.imem_req_valid), 32'd0);
        check_eq("rst_req_addr", fbus.imem_req_addr, RESET_PC);
        check_eq("rst_dec_valid", 32'(fbus.dec_valid), 32'd0);
        check_eq("rst_dec_inst", fbus.dec_inst, NOP);
        check_eq("rst_dec_pc", fbus.dec_pc, 32'd0);
        just_reset = 0;
      end
      stale_n = 0;
      foreach (memq[i]) if (memq[i].stale) stale_n++;
      exp_req = (up >= 1) && (stale_n == 0) && (memq.size() + expq.size() < DEPTH) && !redir_req;
      check_eq("req_valid", 32'(fbus.imem_req_valid), 32'(exp_req));
      if (exp_req) check_eq("req_addr", fbus.imem_req_addr, exp_pc);
      check_eq("dec_valid", 32'(fbus.dec_valid), 32'(expq.size() != 0));
      if (expq.size() != 0) begin
        check_eq("dec_pc", fbus.dec_pc, expq[0].pc);
        check_eq("dec_inst", fbus.dec_inst, expq[0].inst);
      end
      if (fbus.dec_valid && first_dec_up < 0) first_dec_up = int'(up);
      if (fbus.dec_valid && rdy_cfg && !redir_req) begin
        hs_cnt++;
        if (want_post_redir) begin
          post_redir_pc   = fbus.dec_pc;
          want_post_redir = 0;
        end
        if (expq.size() != 0) void'(expq.pop_front());
      end
      if (rv) begin
        m = memq.pop_front();
        if (!m.stale && !redir_req) expq.push_back(dec_t'{m.addr, mem_data(m.addr)});
        else dropped_cnt++;
      end
      if (fbus.imem_req_valid && !fbus.imem_req_ready) stall_seen++;
      if (fbus.imem_req_valid && fbus.imem_req_ready) begin
        memq.push_back(mem_t'{fbus.imem_req_addr, cyc + lat, 1'b0});
        nreq++;
        if (first_req_up < 0) begin
          first_req_up   = int'(up);
          first_req_addr = fbus.imem_req_addr;
        end
        if (last_acc == 32'hFFFF_FFFC && fbus.imem_req_addr == 32'h0) saw_wrap = 1;
        last_acc = fbus.imem_req_addr;
        exp_pc   = exp_pc + 32'd4;
      end
      if (redir_req) begin
        expq.delete();
        foreach (memq[i]) memq[i].stale = 1;
        exp_pc          = {redir_target[31:2], 2'b00};
        want_post_redir = 1;
      end
      up++;
    end
    redir_req = 0;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input int unsigned n);
    rst_n = 1'b0;
    repeat (n) do_cycle();
    rst_n           = 1'b1;
    first_req_up    = -1;
    first_dec_up    = -1;
    nreq            = 0;
    hs_cnt          = 0;
    dropped_cnt     = 0;
    stall_seen      = 0;
    saw_wrap        = 0;
    want_post_redir = 0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redir_req    = 1;
    redir_target = target;
    do_cycle();
  endtask

  initial begin
    int unsigned exp_drops;
    rst_n               = 1'b0;
    fbus.imem_req_ready = 1'b0;
    fbus.imem_rsp_valid = 1'b0;
    fbus.imem_rsp_data  = '0;
    fbus.redirect_valid = 1'b0;
    fbus.redirect_pc    = '0;
    fbus.dec_ready      = 1'b0;
    @(negedge clk);

    // Boot: first request one cycle after BOOT, decode two cycles later
    lat = 1; rdy_cfg = 1;
    apply_reset(2);
    repeat (12) do_cycle();
    check_eq("t1_first_req_cycle", 32'(first_req_up), 32'd1);
    check_eq("t1_first_req_addr", first_req_addr, 32'h100);
    check_eq("t1_first_dec_cycle", 32'(first_dec_up), 32'd3);
    check_eq("t1_progress", 32'(hs_cnt >= 5), 32'd1);

    // Backpressure: only DEPTH requests while decode stalls
    apply_reset(2);
    rdy_cfg = 0;
    repeat (11) do_cycle();
    check_eq("t2_req_count", 32'(nreq), 32'd2);
    check_eq("t2_req_idle", 32'(fbus.imem_req_valid), 32'd0);
    rdy_cfg = 1;
    repeat (12) do_cycle();
    check_eq("t2_drained", 32'(hs_cnt >= 3), 32'd1);

    // Redirect with two responses still in flight
    apply_reset(2);
    lat = 3;
    for (int i = 0; i < 20 && memq.size() < 2; i++) do_cycle();
    check_eq("t3_two_outstanding", 32'(memq.size()), 32'd2);
    exp_drops   = memq.size();
    dropped_cnt = 0;
    redirect_to(32'h200);
    repeat (15) do_cycle();
    check_eq("t3_dropped", 32'(dropped_cnt), 32'(exp_drops));
    check_eq("t3_first_pc", post_redir_pc, 32'h200);

    // Redirect coinciding with a response and a decode handshake
    apply_reset(2);
    lat = 2;
    for (int i = 0; i < 30 && !((memq.size() != 0) && (memq[0].due <= cyc) && (expq.size() != 0)); i++)
      do_cycle();
    check_eq("t4_collision_found", 32'((memq.size() != 0) && (memq[0].due <= cyc) && (expq.size() != 0)), 32'd1);
    exp_drops   = memq.size();
    dropped_cnt = 0;
    redirect_to(32'h203);
    repeat (12) do_cycle();
    check_eq("t4_dropped", 32'(dropped_cnt), 32'(exp_drops));
    check_eq("t4_first_pc", post_redir_pc, 32'h200);

    // Address wrap and memory stall holding the request
    apply_reset(2);
    lat = 1; rdy_cfg = 0;
    for (int i = 0; i < 20 && !(memq.size() == 0 && expq.size() == DEPTH); i++) do_cycle();
    check_eq("t5_fifo_full", 32'(expq.size()), 32'(DEPTH));
    redirect_to(32'hFFFF_FFF4);
    rdy_cfg    = 1;
    stall_left = 4;
    stall_seen = 0;
    repeat (14) do_cycle();
    check_eq("t5_stall_cycles", 32'(stall_seen), 32'd4);
    check_eq("t5_wrap", 32'(saw_wrap), 32'd1);

    // Reset while draining stale responses
    apply_reset(2);
    lat = 3;
    for (int i = 0; i < 20 && memq.size() < 2; i++) do_cycle();
    redirect_to(32'h300);
    apply_reset(1);
    repeat (10) do_cycle();
    check_eq("t6_restart_addr", first_req_addr, RESET_PC);
    check_eq("t6_restart_cycle", 32'(first_req_up), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
